alu_issue_wb: RTL and testbench

- Sequencer that drives the combinational ALU: accepts one decoded ALU instruction per handshake and reads both source registers from the register file.
- Presents the captured operands and op code to the ALU, then captures the result and flags.
- Writes the result back to the register file and holds the architectural flags register.
- Sits between the decode stage and the ALU/register file.
- Multi-cycle and non-pipelined: one instruction in flight at a time.

---
 rtl/fusion_alu_pkg.sv | 45 ++++
 rtl/alu_op_class.sv | 37 +++
 rtl/alu_issue_wb.sv | 145 ++++++++++++++
 tb/tb_alu_issue_wb.sv | 312 +++++++++++++++++++++++++++++++
 4 files changed

// File: rtl/fusion_alu_pkg.sv
// Shared definitions for the ALU issue/write-back sequencer: op codes, flag bit positions, FSM states.
// Latency: none (declarations only).
// Backpressure: none (declarations only).
package fusion_alu_pkg;

   // ALU op codes; anything not listed here is reserved
   localparam logic [4:0] OP_NOP = 5'd0;
   localparam logic [4:0] OP_AND = 5'd1;
   localparam logic [4:0] OP_OR  = 5'd2;
   localparam logic [4:0] OP_XOR = 5'd3;
   localparam logic [4:0] OP_NOT = 5'd4;
   localparam logic [4:0] OP_SHL = 5'd5;
   localparam logic [4:0] OP_SHR = 5'd6;
   localparam logic [4:0] OP_SCR = 5'd7;
   localparam logic [4:0] OP_CMP = 5'd8;
   localparam logic [4:0] OP_ADD = 5'd16;
   localparam logic [4:0] OP_SUB = 5'd17;
   localparam logic [4:0] OP_INC = 5'd18;
   localparam logic [4:0] OP_DEC = 5'd19;

   // Bit positions inside the architectural flags register
   localparam int FLAG_CARRY = 0;
   localparam int FLAG_OVF   = 1;
   localparam int FLAG_NEG   = 2;
   localparam int FLAG_PAR   = 3;
   localparam int FLAG_ZERO  = 4;
   localparam int FLAG_W     = 5;

   // Sequencer states: one instruction walks IDLE -> READ -> EXEC -> WB
   typedef enum logic [1:0] {
      ST_IDLE = 2'd0,
      ST_READ = 2'd1,
      ST_EXEC = 2'd2,
      ST_WB   = 2'd3
   } state_t;

   // Decoded op code class
   typedef struct packed {
      logic nop;
      logic writeback;
      logic carry_update;
      logic illegal;
   } op_class_t;

endpackage

// File: rtl/alu_op_class.sv
// Classifies an ALU op code into nop / write-back / carry-updating / reserved.
// Latency: purely combinational.
// Backpressure: none; follows its input every cycle.
module alu_op_class
   import fusion_alu_pkg::*;
#(
   parameter int OP_W = 5
) (
   input  logic [OP_W-1:0] op_code,
   output logic            is_nop,
   output logic            is_writeback,
   output logic            is_carry_update,
   output logic            is_illegal
);

   // Decode the op code; every unlisted encoding is reserved
   always_comb begin
      is_nop          = 1'b0;
      is_writeback    = 1'b0;
      is_carry_update = 1'b0;
      is_illegal      = 1'b0;
      case (op_code)
         OP_W'(OP_NOP): is_nop = 1'b1;
         OP_W'(OP_AND), OP_W'(OP_OR),  OP_W'(OP_XOR), OP_W'(OP_NOT),
         OP_W'(OP_SHL), OP_W'(OP_SHR), OP_W'(OP_SCR), OP_W'(OP_CMP):
            is_writeback = 1'b1;
         OP_W'(OP_ADD), OP_W'(OP_SUB): begin
            is_writeback    = 1'b1;
            is_carry_update = 1'b1;
         end
         OP_W'(OP_INC), OP_W'(OP_DEC):
            is_writeback = 1'b1;
         default: is_illegal = 1'b1;
      endcase
   end

endmodule

// File: rtl/alu_issue_wb.sv
// Sequences one decoded ALU instruction through register read, ALU execute and write-back; owns the flags register.
// Latency: handshake at cycle T, rf_we/done at T+3, next accept at T+4 (one instruction per 4 cycles).
// Backpressure: in_ready is high only in IDLE; decode must hold a pending instruction stable while it is low.
module alu_issue_wb
   import fusion_alu_pkg::*;
#(
   parameter int DATA_W     = 32,
   parameter int REG_ADDR_W = 5,
   parameter int OP_W       = 5
) (
   input  logic                  clk,
   input  logic                  rst,
   input  logic                  in_valid,
   output logic                  in_ready,
   input  logic [OP_W-1:0]       in_op_code,
   input  logic [REG_ADDR_W-1:0] in_rs_a,
   input  logic [REG_ADDR_W-1:0] in_rs_b,
   input  logic [REG_ADDR_W-1:0] in_rd,
   output logic [REG_ADDR_W-1:0] rf_raddr_a,
   output logic [REG_ADDR_W-1:0] rf_raddr_b,
   input  logic [DATA_W-1:0]     rf_rdata_a,
   input  logic [DATA_W-1:0]     rf_rdata_b,
   output logic [DATA_W-1:0]     alu_op_a,
   output logic [DATA_W-1:0]     alu_op_b,
   output logic [OP_W-1:0]       alu_op_code,
   input  logic [DATA_W-1:0]     alu_out,
   input  logic                  alu_flag_carry,
   input  logic                  alu_flag_overflow,
   input  logic                  alu_flag_parity,
   input  logic                  alu_flag_neg,
   output logic                  rf_we,
   output logic [REG_ADDR_W-1:0] rf_waddr,
   output logic [DATA_W-1:0]     rf_wdata,
   output logic [4:0]            flags_q,
   output logic                  done,
   output logic                  err_illegal
);

   state_t                  state;
   logic [OP_W-1:0]         op_q;        // op code of the instruction in flight
   logic [REG_ADDR_W-1:0]   rd_q;        // destination of the instruction in flight
   logic [DATA_W-1:0]       res_q;       // ALU result captured at the end of EXEC
   logic                    carry_cap;   // ALU flags captured alongside res_q
   logic                    ovf_cap;
   logic                    neg_cap;
   logic                    par_cap;
   op_class_t               cls;
   logic                    unused_nop;

   // Classification is taken from the captured op code so it is stable for the whole instruction
   alu_op_class #(
      .OP_W (OP_W)
   ) u_op_class (
      .op_code         (op_q),
      .is_nop          (cls.nop),
      .is_writeback    (cls.writeback),
      .is_carry_update (cls.carry_update),
      .is_illegal      (cls.illegal)
   );

   // NOP needs no action of its own: it simply is neither write-back nor illegal
   assign unused_nop = cls.nop;

   assign in_ready = (state == ST_IDLE);

   // Read addresses go out in the accept cycle so data arrives for READ; zero otherwise
   assign rf_raddr_a = (state == ST_IDLE && in_valid && !rst) ? in_rs_a : '0;
   assign rf_raddr_b = (state == ST_IDLE && in_valid && !rst) ? in_rs_b : '0;

   // The captured result doubles as the write-back data
   assign rf_wdata = res_q;

   // Instruction sequencer: state, operand/result capture, write-back strobes and flags
   always_ff @(posedge clk) begin
      if (rst) begin
         state       <= ST_IDLE;
         op_q        <= '0;
         rd_q        <= '0;
         res_q       <= '0;
         carry_cap   <= 1'b0;
         ovf_cap     <= 1'b0;
         neg_cap     <= 1'b0;
         par_cap     <= 1'b0;
         alu_op_a    <= '0;
         alu_op_b    <= '0;
         alu_op_code <= '0;
         rf_we       <= 1'b0;
         rf_waddr    <= '0;
         flags_q     <= '0;
         done        <= 1'b0;
         err_illegal <= 1'b0;
      end else begin
         // Strobes are single-cycle; only the EXEC->WB transition raises them
         rf_we       <= 1'b0;
         done        <= 1'b0;
         err_illegal <= 1'b0;
         case (state)
            ST_IDLE: begin
               if (in_valid) begin
                  op_q  <= in_op_code;
                  rd_q  <= in_rd;
                  state <= ST_READ;
               end
            end
            ST_READ: begin
               // Register file data is valid now; present it to the ALU for EXEC
               alu_op_a    <= rf_rdata_a;
               alu_op_b    <= rf_rdata_b;
               alu_op_code <= op_q;
               state       <= ST_EXEC;
            end
            ST_EXEC: begin
               res_q       <= alu_out;
               carry_cap   <= alu_flag_carry;
               ovf_cap     <= alu_flag_overflow;
               neg_cap     <= alu_flag_neg;
               par_cap     <= alu_flag_parity;
               // Back to NOP outside EXEC; operands keep their last values
               alu_op_code <= '0;
               rf_waddr    <= rd_q;
               // Register 0 is hardwired zero, so never write it
               rf_we       <= cls.writeback && (rd_q != '0);
               done        <= 1'b1;
               err_illegal <= cls.illegal;
               state       <= ST_WB;
            end
            ST_WB: begin
               // Flags follow write-back-class ops only, even when rd is register 0
               if (cls.writeback) begin
                  if (cls.carry_update) begin
                     flags_q[FLAG_CARRY] <= carry_cap;
                  end
                  flags_q[FLAG_OVF]  <= ovf_cap;
                  flags_q[FLAG_NEG]  <= neg_cap;
                  flags_q[FLAG_PAR]  <= par_cap;
                  flags_q[FLAG_ZERO] <= (res_q == '0);
               end
               state <= ST_IDLE;
            end
            default: state <= ST_IDLE;
         endcase
      end
   end

endmodule

// File: tb/tb_alu_issue_wb.sv
// Directed bench for alu_issue_wb with a register file model and a small ALU model.
// Latency: checks write-back/done three cycles after each accept and accepts every fourth cycle.
// Backpressure: holds in_valid through in_ready=0 in the back-to-back scenario.
module tb_alu_issue_wb;

   logic        clk = 1'b0;
   logic        rst;
   logic        in_valid;
   logic        in_ready;
   logic [4:0]  in_op_code;
   logic [4:0]  in_rs_a;
   logic [4:0]  in_rs_b;
   logic [4:0]  in_rd;
   logic [4:0]  rf_raddr_a;
   logic [4:0]  rf_raddr_b;
   logic [31:0] rf_rdata_a;
   logic [31:0] rf_rdata_b;
   logic [31:0] alu_op_a;
   logic [31:0] alu_op_b;
   logic [4:0]  alu_op_code;
   logic [31:0] alu_out;
   logic        alu_flag_carry;
   logic        alu_flag_overflow;
   logic        alu_flag_parity;
   logic        alu_flag_neg;
   logic        rf_we;
   logic [4:0]  rf_waddr;
   logic [31:0] rf_wdata;
   logic [4:0]  flags_q;
   logic        done;
   logic        err_illegal;

   int n_cmp = 0;
   int n_bad = 0;

   logic [31:0] regs [32];

   alu_issue_wb #(
      .DATA_W     (32),
      .REG_ADDR_W (5),
      .OP_W       (5)
   ) dut (
      .clk               (clk),
      .rst               (rst),
      .in_valid          (in_valid),
      .in_ready          (in_ready),
      .in_op_code        (in_op_code),
      .in_rs_a           (in_rs_a),
      .in_rs_b           (in_rs_b),
      .in_rd             (in_rd),
      .rf_raddr_a        (rf_raddr_a),
      .rf_raddr_b        (rf_raddr_b),
      .rf_rdata_a        (rf_rdata_a),
      .rf_rdata_b        (rf_rdata_b),
      .alu_op_a          (alu_op_a),
      .alu_op_b          (alu_op_b),
      .alu_op_code       (alu_op_code),
      .alu_out           (alu_out),
      .alu_flag_carry    (alu_flag_carry),
      .alu_flag_overflow (alu_flag_overflow),
      .alu_flag_parity   (alu_flag_parity),
      .alu_flag_neg      (alu_flag_neg),
      .rf_we             (rf_we),
      .rf_waddr          (rf_waddr),
      .rf_wdata          (rf_wdata),
      .flags_q           (flags_q),
      .done              (done),
      .err_illegal       (err_illegal)
   );

   always #5 clk = ~clk;

   // Register file model: one-cycle read latency, preset contents on reset
   always @(posedge clk) begin
      if (rst) begin
         for (int i = 0; i < 32; i++) regs[i] <= 32'h0;
         regs[1] <= 32'hFFFF_FFFF;
         regs[2] <= 32'h0000_0001;
         regs[5] <= 32'h8000_0005;
         regs[6] <= 32'h0000_0005;
      end else if (rf_we) begin
         regs[rf_waddr] <= rf_wdata;
      end
      rf_rdata_a <= regs[rf_raddr_a];
      rf_rdata_b <= regs[rf_raddr_b];
   end

   // ALU model: logic ops report carry=1 so a wrongly updated carry is visible
   always_comb begin
      logic [32:0] s;
      s                 = 33'h0;
      alu_out           = 32'h0;
      alu_flag_carry    = 1'b0;
      alu_flag_overflow = 1'b0;
      case (alu_op_code)
         5'd16: begin
            s                 = {1'b0, alu_op_a} + {1'b0, alu_op_b};
            alu_out           = s[31:0];
            alu_flag_carry    = s[32];
            alu_flag_overflow = (alu_op_a[31] == alu_op_b[31]) && (s[31] != alu_op_a[31]);
         end
         5'd17: begin
            alu_out           = alu_op_a - alu_op_b;
            alu_flag_carry    = (alu_op_a < alu_op_b);
            alu_flag_overflow = (alu_op_a[31] != alu_op_b[31]) && (alu_out[31] != alu_op_a[31]);
         end
         5'd1: begin
            alu_out        = alu_op_a & alu_op_b;
            alu_flag_carry = 1'b1;
         end
         default: begin
            alu_out           = 32'h1234_5678 ^ alu_op_a;
            alu_flag_carry    = 1'b1;
            alu_flag_overflow = 1'b1;
         end
      endcase
      alu_flag_neg    = alu_out[31];
      alu_flag_parity = ^alu_out;
   end

   // Present one instruction for its accept cycle (called at posedge+1 with the DUT idle)
   task automatic send(input logic [4:0] op, input logic [4:0] ra, input logic [4:0] rb, input logic [4:0] rd);
      in_valid   = 1'b1;
      in_op_code = op;
      in_rs_a    = ra;
      in_rs_b    = rb;
      in_rd      = rd;
      @(posedge clk);
      #1;
      in_valid   = 1'b0;
      in_op_code = 5'd0;
      in_rs_a    = 5'd0;
      in_rs_b    = 5'd0;
      in_rd      = 5'd0;
   endtask

   // Wait (bounded) for done; lat counts cycles after the accept cycle, 0 if it never came
   task automatic wait_done(output int lat, output logic we, output logic [4:0] wa,
                            output logic [31:0] wd, output logic err, output int stray);
      lat = 0; we = 1'b0; wa = 5'd0; wd = 32'h0; err = 1'b0; stray = 0;
      for (int i = 1; i <= 10; i++) begin
         @(negedge clk);
         if (done) begin
            lat = i; we = rf_we; wa = rf_waddr; wd = rf_wdata; err = err_illegal;
            break;
         end
         if (rf_we || err_illegal) stray++;
      end
      @(posedge clk);
      #1;
   endtask

   task automatic test_reset();
      rst = 1'b1; in_valid = 1'b0; in_op_code = 5'd0; in_rs_a = 5'd0; in_rs_b = 5'd0; in_rd = 5'd0;
      repeat (2) @(posedge clk);
      #1;
      n_cmp++; if (in_ready !== 1'b1) begin n_bad++; $display("FAIL reset_in_ready: got %b want 1", in_ready); end
      n_cmp++; if (rf_we !== 1'b0) begin n_bad++; $display("FAIL reset_rf_we: got %b want 0", rf_we); end
      n_cmp++; if (done !== 1'b0) begin n_bad++; $display("FAIL reset_done: got %b want 0", done); end
      n_cmp++; if (err_illegal !== 1'b0) begin n_bad++; $display("FAIL reset_err: got %b want 0", err_illegal); end
      n_cmp++; if (flags_q !== 5'b0) begin n_bad++; $display("FAIL reset_flags: got %b want 00000", flags_q); end
      n_cmp++; if (alu_op_code !== 5'd0) begin n_bad++; $display("FAIL reset_alu_op_code: got %0d want 0", alu_op_code); end
      n_cmp++; if ({alu_op_a, alu_op_b} !== 64'h0) begin n_bad++; $display("FAIL reset_alu_ops: got %h %h want 0 0", alu_op_a, alu_op_b); end
      n_cmp++; if ({rf_waddr, rf_wdata} !== 37'h0) begin n_bad++; $display("FAIL reset_wb_bus: got %0d %h want 0 0", rf_waddr, rf_wdata); end
      n_cmp++; if ({rf_raddr_a, rf_raddr_b} !== 10'h0) begin n_bad++; $display("FAIL reset_raddr: got %0d %0d want 0 0", rf_raddr_a, rf_raddr_b); end
      rst = 1'b0;
      @(posedge clk);
      #1;
   endtask

   // ADD r3 = r1 + r2 = 0xFFFFFFFF + 1 -> 0 with carry out
   task automatic test_add();
      int lat, stray; logic we, err; logic [4:0] wa; logic [31:0] wd;
      in_valid = 1'b1; in_op_code = 5'd16; in_rs_a = 5'd1; in_rs_b = 5'd2; in_rd = 5'd3;
      #1;
      n_cmp++; if ({rf_raddr_a, rf_raddr_b} !== {5'd1, 5'd2}) begin n_bad++; $display("FAIL add_raddr: got %0d %0d want 1 2", rf_raddr_a, rf_raddr_b); end
      @(posedge clk);
      #1;
      in_valid = 1'b0; in_op_code = 5'd0; in_rs_a = 5'd0; in_rs_b = 5'd0; in_rd = 5'd0;
      wait_done(lat, we, wa, wd, err, stray);
      n_cmp++; if (lat !== 3) begin n_bad++; $display("FAIL add_latency: got %0d want 3", lat); end
      n_cmp++; if (we !== 1'b1) begin n_bad++; $display("FAIL add_rf_we: got %b want 1", we); end
      n_cmp++; if (wa !== 5'd3) begin n_bad++; $display("FAIL add_waddr: got %0d want 3", wa); end
      n_cmp++; if (wd !== 32'h0) begin n_bad++; $display("FAIL add_wdata: got %h want 00000000", wd); end
      n_cmp++; if (err !== 1'b0) begin n_bad++; $display("FAIL add_err: got %b want 0", err); end
      n_cmp++; if (stray !== 0) begin n_bad++; $display("FAIL add_stray_strobe: got %0d want 0", stray); end
      n_cmp++; if (flags_q !== 5'b10001) begin n_bad++; $display("FAIL add_flags: got %b want 10001", flags_q); end
   endtask

   // SUB r4 = r5 - r6 = 0x80000000 (neg), then AND r7 = r1 & r2 = 1 must keep SUB's carry
   task automatic test_sub_and();
      int lat, stray; logic we, err; logic [4:0] wa; logic [31:0] wd;
      send(5'd17, 5'd5, 5'd6, 5'd4);
      wait_done(lat, we, wa, wd, err, stray);
      n_cmp++; if ({we, wa} !== {1'b1, 5'd4}) begin n_bad++; $display("FAIL sub_wb: got we=%b waddr=%0d want we=1 waddr=4", we, wa); end
      n_cmp++; if (wd !== 32'h8000_0000) begin n_bad++; $display("FAIL sub_wdata: got %h want 80000000", wd); end
      n_cmp++; if (flags_q !== 5'b01100) begin n_bad++; $display("FAIL sub_flags: got %b want 01100", flags_q); end
      send(5'd1, 5'd1, 5'd2, 5'd7);
      wait_done(lat, we, wa, wd, err, stray);
      n_cmp++; if ({we, wa, wd} !== {1'b1, 5'd7, 32'h1}) begin n_bad++; $display("FAIL and_wb: got we=%b waddr=%0d wdata=%h want 1 7 00000001", we, wa, wd); end
      n_cmp++; if (flags_q !== 5'b01000) begin n_bad++; $display("FAIL and_flags: got %b want 01000", flags_q); end
      n_cmp++; if (regs[7] !== 32'h1) begin n_bad++; $display("FAIL and_reg7: got %h want 00000001", regs[7]); end
   endtask

   // Reserved op 10: done and err_illegal together, no write-back, flags unchanged
   task automatic test_illegal();
      int lat, stray; logic we, err; logic [4:0] wa; logic [31:0] wd;
      send(5'b01010, 5'd1, 5'd2, 5'd9);
      wait_done(lat, we, wa, wd, err, stray);
      n_cmp++; if (lat !== 3) begin n_bad++; $display("FAIL illegal_latency: got %0d want 3", lat); end
      n_cmp++; if (err !== 1'b1) begin n_bad++; $display("FAIL illegal_err_with_done: got %b want 1", err); end
      n_cmp++; if (we !== 1'b0) begin n_bad++; $display("FAIL illegal_rf_we: got %b want 0", we); end
      n_cmp++; if (stray !== 0) begin n_bad++; $display("FAIL illegal_stray_strobe: got %0d want 0", stray); end
      n_cmp++; if (flags_q !== 5'b01000) begin n_bad++; $display("FAIL illegal_flags: got %b want 01000", flags_q); end
      n_cmp++; if (err_illegal !== 1'b0) begin n_bad++; $display("FAIL illegal_pulse_len: got %b want 0", err_illegal); end
   endtask

   // ADD to r0: write suppressed, flags still follow (0xFFFFFFFE, carry, neg, odd parity)
   task automatic test_rd0();
      int lat, stray; logic we, err; logic [4:0] wa; logic [31:0] wd;
      send(5'd16, 5'd1, 5'd1, 5'd0);
      wait_done(lat, we, wa, wd, err, stray);
      n_cmp++; if (lat !== 3) begin n_bad++; $display("FAIL rd0_done: got latency %0d want 3", lat); end
      n_cmp++; if ({we, stray} !== {1'b0, 32'd0}) begin n_bad++; $display("FAIL rd0_rf_we: got we=%b stray=%0d want 0 0", we, stray); end
      n_cmp++; if (flags_q !== 5'b01101) begin n_bad++; $display("FAIL rd0_flags: got %b want 01101", flags_q); end
      n_cmp++; if (regs[0] !== 32'h0) begin n_bad++; $display("FAIL rd0_reg0: got %h want 00000000", regs[0]); end
   endtask

   // NOP: done pulses, nothing written, flags untouched
   task automatic test_nop();
      int lat, stray; logic we, err; logic [4:0] wa; logic [31:0] wd;
      send(5'd0, 5'd1, 5'd2, 5'd12);
      wait_done(lat, we, wa, wd, err, stray);
      n_cmp++; if ({lat, we, err} !== {32'd3, 1'b0, 1'b0}) begin n_bad++; $display("FAIL nop_retire: got lat=%0d we=%b err=%b want 3 0 0", lat, we, err); end
      n_cmp++; if (flags_q !== 5'b01101) begin n_bad++; $display("FAIL nop_flags: got %b want 01101", flags_q); end
   endtask

   // Reset while in EXEC aborts the instruction
   task automatic test_abort();
      int hits;
      send(5'd16, 5'd1, 5'd2, 5'd11);
      @(posedge clk);
      #1;
      n_cmp++; if ({alu_op_code, alu_op_a, alu_op_b} !== {5'd16, 32'hFFFF_FFFF, 32'h1}) begin n_bad++; $display("FAIL exec_drive: got op=%0d a=%h b=%h want 16 ffffffff 00000001", alu_op_code, alu_op_a, alu_op_b); end
      rst = 1'b1;
      @(posedge clk);
      #1;
      rst = 1'b0;
      n_cmp++; if (in_ready !== 1'b1) begin n_bad++; $display("FAIL abort_in_ready: got %b want 1", in_ready); end
      n_cmp++; if (flags_q !== 5'b0) begin n_bad++; $display("FAIL abort_flags: got %b want 00000", flags_q); end
      n_cmp++; if (alu_op_code !== 5'd0) begin n_bad++; $display("FAIL abort_alu_op_code: got %0d want 0", alu_op_code); end
      hits = 0;
      for (int i = 0; i < 6; i++) begin
         @(negedge clk);
         if (rf_we || done) hits++;
      end
      n_cmp++; if (hits !== 0) begin n_bad++; $display("FAIL abort_no_retire: got %0d strobe cycles want 0", hits); end
      n_cmp++; if (regs[11] !== 32'h0) begin n_bad++; $display("FAIL abort_reg11: got %h want 00000000", regs[11]); end
      @(posedge clk);
      #1;
   endtask

   // Three dependent ADDs with in_valid held: accepts every fourth cycle
   task automatic test_back_to_back();
      logic [4:0] ops [3][4];
      int acc [3];
      logic rdy [13];
      int k;
      ops[0] = '{5'd16, 5'd2, 5'd2, 5'd8};
      ops[1] = '{5'd16, 5'd8, 5'd2, 5'd9};
      ops[2] = '{5'd16, 5'd9, 5'd9, 5'd10};
      k = 0;
      for (int i = 0; i < 3; i++) acc[i] = -1;
      in_valid = 1'b1;
      {in_op_code, in_rs_a, in_rs_b, in_rd} = {ops[0][0], ops[0][1], ops[0][2], ops[0][3]};
      for (int c = 0; c < 13; c++) begin
         @(negedge clk);
         rdy[c] = in_ready;
         @(posedge clk);
         #1;
         if (in_valid && rdy[c]) begin
            acc[k] = c;
            k++;
            if (k < 3) {in_op_code, in_rs_a, in_rs_b, in_rd} = {ops[k][0], ops[k][1], ops[k][2], ops[k][3]};
            else in_valid = 1'b0;
         end
      end
      in_valid = 1'b0;
      n_cmp++; if (acc[0] !== 0) begin n_bad++; $display("FAIL b2b_accept0: got %0d want 0", acc[0]); end
      n_cmp++; if (acc[1] !== 4) begin n_bad++; $display("FAIL b2b_accept1: got %0d want 4", acc[1]); end
      n_cmp++; if (acc[2] !== 8) begin n_bad++; $display("FAIL b2b_accept2: got %0d want 8", acc[2]); end
      for (int c = 0; c < 13; c++) begin
         n_cmp++;
         if (rdy[c] !== ((c % 4) == 0)) begin n_bad++; $display("FAIL b2b_in_ready_c%0d: got %b want %b", c, rdy[c], (c % 4) == 0); end
      end
      n_cmp++; if ({regs[8], regs[9], regs[10]} !== {32'd2, 32'd3, 32'd6}) begin n_bad++; $display("FAIL b2b_results: got %h %h %h want 2 3 6", regs[8], regs[9], regs[10]); end
   endtask

   initial begin
      test_reset();
      test_add();
      test_sub_and();
      test_illegal();
      test_rd0();
      test_nop();
      test_abort();
      test_back_to_back();
      $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
      $finish;
   end

endmodule
